// File: rtl/ram_be_pipe.sv
// ram_be_pipe: single-port RAM with active-low byte enables,
// valid/ready requests, optional output register and zero-fill after reset.
module ram_be_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 13,
    parameter int OUT_REG   = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                rnw,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be_b,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   dout,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] fill_cnt_nx;
    logic              fill_we;
    logic              acc;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] mem [DEPTH];

    assign acc   = req_valid & req_ready;
    assign wr_en = acc & ~rnw & reset_b;
    assign rd_en = acc & rnw;

    // Next state and fill counter: step through every word, then serve requests.
    always_comb begin
        state_nx    = state;
        fill_cnt_nx = fill_cnt;
        fill_we     = 1'b0;
        unique case (state)
            INIT: begin
                fill_we     = reset_b;
                fill_cnt_nx = fill_cnt + ADDR_W'(1);
                if (&fill_cnt) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // Control registers; ready/done mirror the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state     <= (INIT_ZERO != 0) ? INIT : RUN;
            fill_cnt  <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            fill_cnt  <= fill_cnt_nx;
            req_ready <= (state_nx == RUN);
            init_done <= (state_nx == RUN);
        end
    end

    // Storage: fill writes zero words, requests write only enabled lanes.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (!be_b[i]) begin
                    mem[address][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_pipe
            logic              p_valid;
            logic [DATA_W-1:0] p_data;

            // Two-stage read: array read into p_data, then onto dout.
            always_ff @(posedge clk) begin
                if (!reset_b) begin
                    p_valid  <= 1'b0;
                    p_data   <= '0;
                    rd_valid <= 1'b0;
                    dout     <= '0;
                end else begin
                    p_valid  <= rd_en;
                    rd_valid <= p_valid;
                    if (rd_en) begin
                        p_data <= mem[address];
                    end
                    if (p_valid) begin
                        dout <= p_data;
                    end
                end
            end
        end else begin : g_direct
            // Single-stage read: array read lands on dout directly.
            always_ff @(posedge clk) begin
                if (!reset_b) begin
                    rd_valid <= 1'b0;
                    dout     <= '0;
                end else begin
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        dout <= mem[address];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_be_pipe.sv
// tb_ram_be_pipe: scoreboard bench driving a 1-cycle and a 2-cycle
// instance with the same requests against an array reference model.
module tb_ram_be_pipe;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        req_valid;
    logic        rnw;
    logic [3:0]  address;
    logic [31:0] din;
    logic [3:0]  be_b;

    logic        req_ready0, rd_valid0, init_done0;
    logic [31:0] dout0;
    logic        req_ready1, rd_valid1, init_done1;
    logic [31:0] dout1;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [16];
    logic [31:0] exp_dout0;
    logic [31:0] exp_dout1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_on = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ram_be_pipe #(
        .DATA_W(32), .ADDR_W(4), .OUT_REG(0), .INIT_ZERO(1)
    ) u0 (
        .clk(clk), .reset_b(reset_b), .req_valid(req_valid),
        .req_ready(req_ready0), .rnw(rnw), .address(address),
        .din(din), .be_b(be_b), .rd_valid(rd_valid0),
        .dout(dout0), .init_done(init_done0)
    );

    ram_be_pipe #(
        .DATA_W(32), .ADDR_W(4), .OUT_REG(1), .INIT_ZERO(1)
    ) u1 (
        .clk(clk), .reset_b(reset_b), .req_valid(req_valid),
        .req_ready(req_ready1), .rnw(rnw), .address(address),
        .din(din), .be_b(be_b), .rd_valid(rd_valid1),
        .dout(dout1), .init_done(init_done1)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // Monitor: pop on every rd_valid, check data and latency; else dout holds.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_on) begin
            if (rd_valid0) begin
                if (q0.size() == 0) begin
                    chk("u0_spurious_rd_valid", rd_valid0, 1'b0);
                end else begin
                    e = q0.pop_front();
                    chk("u0_data", dout0, e.d);
                    chk("u0_latency", cyc, e.c);
                    exp_dout0 = e.d;
                end
            end else begin
                chk("u0_dout_hold", dout0, exp_dout0);
            end
            if (rd_valid1) begin
                if (q1.size() == 0) begin
                    chk("u1_spurious_rd_valid", rd_valid1, 1'b0);
                end else begin
                    e = q1.pop_front();
                    chk("u1_data", dout1, e.d);
                    chk("u1_latency", cyc, e.c);
                    exp_dout1 = e.d;
                end
            end else begin
                chk("u1_dout_hold", dout1, exp_dout1);
            end
        end
    end

    // One request, accepted on the next rising edge (block is in RUN).
    task automatic op(input bit rd, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        rnw       = rd;
        address   = a;
        din       = d;
        be_b      = be;
        if (rd) begin
            q0.push_back('{model[a], cyc + 1});
            q1.push_back('{model[a], cyc + 2});
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!be[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reset with junk writes offered throughout, then time the fill.
    task automatic reset_fill(input int hold);
        reset_b   = 1'b0;
        req_valid = 1'b1;
        rnw       = 1'b0;
        address   = 4'($urandom);
        din       = $urandom;
        be_b      = 4'b0000;
        q1.delete();
        exp_dout0 = '0;
        exp_dout1 = '0;
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_req_ready0", req_ready0, 1'b0);
        chk("rst_req_ready1", req_ready1, 1'b0);
        chk("rst_init_done0", init_done0, 1'b0);
        chk("rst_rd_valid1", rd_valid1, 1'b0);
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        mon_on = 1'b1;
        @(negedge clk);
        reset_b = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("fill_ready0_k%0d", k), req_ready0, (k == 16));
            chk($sformatf("fill_ready1_k%0d", k), req_ready1, (k == 16));
            chk($sformatf("fill_done0_k%0d", k), init_done0, (k == 16));
            chk($sformatf("fill_done1_k%0d", k), init_done1, (k == 16));
        end
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(negedge clk);
    endtask

    initial begin
        exp_dout0 = '0;
        exp_dout1 = '0;
        reset_fill(3);

        for (int i = 0; i < 16; i++) op(1'b1, 4'(i), 32'h0, 4'hF);

        op(1'b0, 4'd5, 32'hAABBCCDD, 4'b0000);
        op(1'b0, 4'd5, 32'h11223344, 4'b1010);
        op(1'b1, 4'd5, 32'h0, 4'b0000);
        idle(1);

        for (int i = 0; i < 4; i++) op(1'b0, 4'(i), 32'h10 + i, 4'b0000);
        for (int i = 0; i < 4; i++) op(1'b1, 4'(i), 32'h0, 4'b0000);
        idle(2);

        op(1'b0, 4'd7, 32'hDEADBEEF, 4'b0000);
        op(1'b1, 4'd7, 32'h0, 4'b0000);
        op(1'b0, 4'd8, 32'h01020304, 4'b0000);
        op(1'b0, 4'd9, 32'h05060708, 4'b0110);
        op(1'b1, 4'd8, 32'h0, 4'b1111);
        op(1'b0, 4'd7, 32'hFFFFFFFF, 4'b1111);
        op(1'b1, 4'd7, 32'h0, 4'b0000);
        idle(5);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(4) == 0) begin
                idle($urandom_range(1, 3));
            end else begin
                op(1'($urandom), 4'($urandom), $urandom, 4'($urandom));
            end
        end
        idle(4);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        op(1'b0, 4'd3, 32'hCAFEF00D, 4'b0000);
        op(1'b1, 4'd3, 32'h0, 4'b0000);
        reset_fill(1);
        for (int i = 0; i < 16; i += 3) op(1'b1, 4'(i), 32'h0, 4'b0000);
        idle(4);
        chk("q0_drained_end", q0.size(), 0);
        chk("q1_drained_end", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
